// File: rtl/rr_txn_arbiter.sv
// rr_txn_arbiter: round-robin arbiter granting one transaction resource to one of
// NUM_REQ agents. The grant is held until the owner ends its transaction, and then
// priority rotates to the agent after the one just served.
// Optional watchdog: define RR_TXN_ARBITER_WATCHDOG_EN to build the hung-grant timeout.
module rr_txn_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNT_W   = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arb_en,
    input  logic [NUM_REQ-1:0] request,
    input  logic [NUM_REQ-1:0] end_transaction,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               busy,
    output logic               timeout_pulse,
    output logic               timeout_err,
    input  logic               err_clr
);

    typedef enum logic {StIdle, StBusy} state_e;

    // Elaboration-time sanity checks on the configuration.
    if (NUM_REQ < 2 || NUM_REQ > 16 || (1 << ID_W) < NUM_REQ) begin : gen_bad_req_cfg
        $error("rr_txn_arbiter: NUM_REQ must be 2..16 and fit in ID_W bits");
    end
    if (TIMEOUT < 2 || TIMEOUT >= (1 << CNT_W)) begin : gen_bad_wd_cfg
        $error("rr_txn_arbiter: TIMEOUT must be >= 2 and fit in CNT_W bits");
    end

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic               busy_q, busy_d;
    logic [ID_W-1:0]    last_q, last_d;

    logic               sel_valid;
    logic [ID_W-1:0]    sel_idx;
    logic [ID_W-1:0]    cand;
    logic               end_hit;
    logic               wd_fire;

    // grant_q is one-hot on the owner, so masking avoids indexing by grant_id.
    assign end_hit = |(end_transaction & grant_q);

    // Pick the first requester in circular order starting just after last_served.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((32'(last_q) + k) % NUM_REQ);
            if (!sel_valid && request[cand]) begin
                sel_valid = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Next-state and registered-output logic for the IDLE/BUSY machine.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        busy_d     = busy_q;
        last_d     = last_q;
        unique case (state_q)
            StIdle: begin
                if (arb_en && sel_valid) begin
                    state_d          = StBusy;
                    grant_d          = '0;
                    grant_d[sel_idx] = 1'b1;
                    grant_id_d       = sel_idx;
                    busy_d           = 1'b1;
                end
            end
            StBusy: begin
                if (end_hit || wd_fire) begin
                    state_d    = StIdle;
                    grant_d    = '0;
                    grant_id_d = '0;
                    busy_d     = 1'b0;
                    last_d     = grant_id_q;
                end
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            last_q     <= ID_W'(NUM_REQ - 1);
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
            last_q     <= last_d;
        end
    end

    assign grant    = grant_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;

`ifdef RR_TXN_ARBITER_WATCHDOG_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             err_q, err_d;

    // Count BUSY cycles; IDLE always precedes BUSY, so the count starts at 0 on entry.
    // A simultaneous end_transaction wins over expiry and is a normal release.
    always_comb begin
        cnt_d   = (state_q == StBusy) ? cnt_q + 1'b1 : '0;
        wd_fire = (state_q == StBusy) && (cnt_q == CNT_W'(TIMEOUT - 1));
        pulse_d = wd_fire && !end_hit;
        err_d   = err_q;
        if (pulse_d) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    // Watchdog counter and error flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            err_q   <= err_d;
        end
    end

    assign timeout_pulse = pulse_q;
    assign timeout_err   = err_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign wd_fire        = 1'b0;
    assign timeout_pulse  = 1'b0;
    assign timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_rr_txn_arbiter.sv
// Self-checking bench for rr_txn_arbiter: a table of directed vectors, hand-written
// corner sequences, and random traffic, all checked against a behavioural model.
module tb_rr_txn_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int TO  = 8;
    localparam int CW  = 4;
`ifdef RR_TXN_ARBITER_WATCHDOG_EN
    localparam bit Wd = 1'b1;
`else
    localparam bit Wd = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           arb_en;
    logic [N-1:0]   request;
    logic [N-1:0]   end_transaction;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           busy;
    logic           timeout_pulse;
    logic           timeout_err;
    logic           err_clr;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: owner, age of the current grant in cycles, last served agent.
    bit m_busy;
    int m_id;
    int m_last;
    int m_age;
    bit m_pulse;
    bit m_err;

    typedef struct {
        logic         en;
        logic [N-1:0] req;
        logic [N-1:0] et;
        logic [N-1:0] exp_grant;
    } vec_t;

    vec_t vecs[15];

    rr_txn_arbiter #(
        .NUM_REQ(N),
        .ID_W   (IDW),
        .TIMEOUT(TO),
        .CNT_W  (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .arb_en         (arb_en),
        .request        (request),
        .end_transaction(end_transaction),
        .grant          (grant),
        .grant_id       (grant_id),
        .busy           (busy),
        .timeout_pulse  (timeout_pulse),
        .timeout_err    (timeout_err),
        .err_clr        (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_id    = 0;
        m_last  = N - 1;
        m_age   = 0;
        m_pulse = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic model_step(input logic en, input logic [N-1:0] req, input logic [N-1:0] et,
                              input logic clr);
        bit to;
        to = 1'b0;
        if (m_busy) begin
            if (et[m_id]) begin
                m_last = m_id;
                m_busy = 1'b0;
            end else if (Wd && m_age >= TO) begin
                m_last = m_id;
                m_busy = 1'b0;
                to     = 1'b1;
            end else begin
                m_age++;
            end
        end else if (en && req != '0) begin
            for (int k = 1; k <= N; k++) begin
                int a;
                a = (m_last + k) % N;
                if (req[a]) begin
                    m_busy = 1'b1;
                    m_id   = a;
                    m_age  = 1;
                    break;
                end
            end
        end
        m_pulse = to;
        if (to) m_err = 1'b1;
        else if (clr && Wd) m_err = 1'b0;
    endtask

    task automatic check_model();
        logic [N-1:0] eg;
        eg = m_busy ? N'(1 << m_id) : '0;
        check("grant", 32'(grant), 32'(eg));
        check("grant_id", 32'(grant_id), m_busy ? 32'(m_id) : 32'd0);
        check("busy", 32'(busy), 32'(m_busy));
        check("timeout_pulse", 32'(timeout_pulse), 32'(m_pulse));
        check("timeout_err", 32'(timeout_err), 32'(m_err));
    endtask

    // One clock: capture the inputs seen by the edge, advance the model, compare after it.
    task automatic tick();
        logic         e;
        logic [N-1:0] r;
        logic [N-1:0] t;
        logic         c;
        e = arb_en;
        r = request;
        t = end_transaction;
        c = err_clr;
        @(posedge clk);
        model_step(e, r, t, c);
        #1;
        check_model();
    endtask

    initial begin
        int held;
        int pulses;

        // Round-robin over all four agents, each released on its third grant cycle.
        for (int g = 0; g < 5; g++) begin
            logic [N-1:0] oh;
            oh = N'(1 << (g % N));
            for (int j = 0; j < 3; j++) begin
                vecs[3*g+j].en        = 1'b1;
                vecs[3*g+j].req       = 4'b1111;
                vecs[3*g+j].et        = (j == 2) ? oh : 4'b0000;
                vecs[3*g+j].exp_grant = (j == 2) ? 4'b0000 : oh;
            end
        end

        rst             = 1'b1;
        arb_en          = 1'b0;
        request         = '0;
        end_transaction = '0;
        err_clr         = 1'b0;
        model_reset();
        #12;
        check("reset_grant", 32'(grant), 32'd0);
        check("reset_id", 32'(grant_id), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_err", 32'(timeout_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            arb_en          = vecs[i].en;
            request         = vecs[i].req;
            end_transaction = vecs[i].et;
            tick();
            check($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].exp_grant));
        end

        // Serve agent 1, then 3 and 0 compete: rotation from 1 picks 3 first.
        request = 4'b0010; end_transaction = 4'b0000; tick();
        request = 4'b0000; end_transaction = 4'b0010; tick();
        request = 4'b1001; end_transaction = 4'b0000; tick();
        check("rot_agent3", 32'(grant), 32'h8);
        request = 4'b0001; end_transaction = 4'b1000; tick();
        end_transaction = 4'b0000; tick();
        check("rot_agent0", 32'(grant), 32'h1);
        request = 4'b0000; end_transaction = 4'b0001; tick();

        // Another agent's end_transaction must not release the grant.
        request = 4'b0100; end_transaction = 4'b0000; tick();
        request = 4'b0000; end_transaction = 4'b0001; tick();
        check("foreign_end_ignored", 32'(grant), 32'h4);
        end_transaction = 4'b0100; tick();
        check("own_end_release", 32'(grant), 32'h0);
        end_transaction = 4'b0000;

        // Global enable low blocks new grants.
        arb_en = 1'b0; request = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("arb_en_off", 32'(grant), 32'h0);
        end
        arb_en = 1'b1; tick();
        check("arb_en_on", 32'(grant), 32'h2);
        request = 4'b0000; end_transaction = 4'b0010; tick();
        end_transaction = 4'b0000;

        // Hung grant: watchdog releases after TO cycles; without it the grant persists.
        request = 4'b0010; tick();
        request = 4'b0000;
        held    = (grant == 4'b0010) ? 1 : 0;
        pulses  = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (grant == 4'b0010) held++;
            if (timeout_pulse) pulses++;
        end
        check("wd_hold_cycles", 32'(held), Wd ? 32'(TO) : 32'd13);
        check("wd_pulse_count", 32'(pulses), Wd ? 32'd1 : 32'd0);
        end_transaction = 4'b0010; tick();
        end_transaction = 4'b0000;
        repeat (3) tick();
        check("wd_err_sticky", 32'(timeout_err), 32'(Wd));
        err_clr = 1'b1; tick();
        err_clr = 1'b0;
        check("wd_err_clr", 32'(timeout_err), 32'd0);

        // End arrives on the last allowed cycle: a normal release, no timeout.
        request = 4'b0010; tick();
        request = 4'b0000;
        repeat (TO - 1) tick();
        end_transaction = 4'b0010; tick();
        end_transaction = 4'b0000;
        check("wd_edge_release", 32'(grant), 32'h0);
        check("wd_edge_no_pulse", 32'(timeout_pulse), 32'd0);
        check("wd_edge_no_err", 32'(timeout_err), 32'd0);

        // Asynchronous reset in the middle of a grant.
        request = 4'b0100; tick();
        check("pre_reset_grant", 32'(grant), 32'h4);
        request = 4'b0000;
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_grant", 32'(grant), 32'h0);
        check("async_reset_busy", 32'(busy), 32'd0);
        model_reset();
        @(negedge clk);
        rst     = 1'b0;
        request = 4'b1111;
        tick();
        check("post_reset_agent0", 32'(grant), 32'h1);
        request = 4'b0000; end_transaction = 4'b0001; tick();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            arb_en          = ($urandom_range(0, 9) != 0);
            request         = N'($urandom);
            end_transaction = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            err_clr         = ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
